// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, NZCV bit positions
// and the control FSM state encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_SRA = 4'd7,
    OP_MUL = 4'd8
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_RUN,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier, one partial product per cycle.
// o_Product is the final sum, valid in the cycle o_Done is high.
module alu_mul_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             i_CLK,
  input  logic             i_RESET_N,
  input  logic             i_Start,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_Product
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] w_acc_nxt;

  assign w_acc_nxt = r_b[0] ? r_acc + r_a : r_acc;
  assign o_Product = w_acc_nxt;
  assign o_Done    = r_busy && (r_cnt == SHW'(WIDTH-1));

  always_ff @(posedge i_CLK) begin
    if (!i_RESET_N) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_Start) begin
      r_a    <= i_A;
      r_b    <= i_B;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + SHW'(1);
      if (o_Done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on both sides,
// single-cycle ops plus an iterative multiplier and NZCV flag register.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             i_CLK,
  input  logic             i_RESET_N,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic [3:0]       i_Op,
  input  logic             i_SetFlags,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [WIDTH-1:0] o_Result,
  output logic [3:0]       o_ResFlags,
  output logic [3:0]       o_Flags
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_resflags;
  logic [3:0]       r_flags;
  logic             r_setf;

  logic             w_acc;
  logic             w_res_acc;
  logic             w_is_mul;
  logic             w_mul_done_raw;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_prod;
  logic [3:0]       w_mul_flags;

  logic [SHW-1:0]   w_sh;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_sll;
  logic [WIDTH:0]   w_srl;
  logic [WIDTH:0]   w_sra;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic [3:0]       w_flags;

  assign o_Ready = i_RESET_N &&
    ((r_state == ST_IDLE) || (r_state == ST_HOLD && i_Ready));
  assign o_Valid    = (r_state == ST_HOLD);
  assign o_Result   = r_result;
  assign o_ResFlags = r_resflags;
  assign o_Flags    = r_flags;

  assign w_acc      = i_Valid && o_Ready;
  assign w_res_acc  = o_Valid && i_Ready;
  assign w_is_mul   = (i_Op == OP_MUL);
  assign w_mul_done = w_mul_done_raw && (r_state == ST_MUL_RUN);

  assign w_sh   = i_B[SHW-1:0];
  assign w_sum  = {1'b0, i_A} + {1'b0, i_B};
  assign w_diff = {1'b0, i_A} - {1'b0, i_B};
  // Extra bit on the shifted side catches the last bit shifted out
  assign w_sll  = {1'b0, i_A} << w_sh;
  assign w_srl  = {i_A, 1'b0} >> w_sh;
  assign w_sra  = $signed({i_A, 1'b0}) >>> w_sh;

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_Op)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (i_A[WIDTH-1] == i_B[WIDTH-1]) &&
                (w_sum[WIDTH-1] != i_A[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = ~w_diff[WIDTH];
        w_v   = (i_A[WIDTH-1] != i_B[WIDTH-1]) &&
                (w_diff[WIDTH-1] != i_A[WIDTH-1]);
      end
      OP_AND: w_res = i_A & i_B;
      OP_OR:  w_res = i_A | i_B;
      OP_XOR: w_res = i_A ^ i_B;
      OP_SLL: begin
        w_res = w_sll[WIDTH-1:0];
        w_c   = w_sll[WIDTH];
      end
      OP_SRL: begin
        w_res = w_srl[WIDTH:1];
        w_c   = w_srl[0];
      end
      OP_SRA: begin
        w_res = w_sra[WIDTH:1];
        w_c   = w_sra[0];
      end
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_N] = w_res[WIDTH-1];
    w_flags[FLAG_Z] = (w_res == '0);
    w_flags[FLAG_C] = w_c;
    w_flags[FLAG_V] = w_v;
    w_mul_flags         = '0;
    w_mul_flags[FLAG_N] = w_prod[WIDTH-1];
    w_mul_flags[FLAG_Z] = (w_prod == '0);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_acc) w_next = w_is_mul ? ST_MUL_RUN : ST_HOLD;
      end
      ST_MUL_RUN: begin
        if (w_mul_done) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (i_Ready) begin
          if (w_acc) w_next = w_is_mul ? ST_MUL_RUN : ST_HOLD;
          else       w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RESET_N) begin
      r_state    <= ST_IDLE;
      r_result   <= '0;
      r_resflags <= '0;
      r_flags    <= '0;
      r_setf     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_res_acc && r_setf) r_flags <= r_resflags;
      if (w_acc) r_setf <= i_SetFlags;
      if (w_acc && !w_is_mul) begin
        r_result   <= w_res;
        r_resflags <= w_flags;
      end
      if (w_mul_done) begin
        r_result   <= w_prod;
        r_resflags <= w_mul_flags;
      end
    end
  end

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_mul (
    .i_CLK     (i_CLK),
    .i_RESET_N (i_RESET_N),
    .i_Start   (w_acc && w_is_mul),
    .i_A       (i_A),
    .i_B       (i_B),
    .o_Done    (w_mul_done_raw),
    .o_Product (w_prod)
  );

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): handshake timing, flags,
// multiplier latency, backpressure and reset abort.
module tb_seq_alu;

  logic        i_CLK = 1'b0;
  logic        i_RESET_N;
  logic        i_Valid;
  logic        o_Ready;
  logic [31:0] i_A;
  logic [31:0] i_B;
  logic [3:0]  i_Op;
  logic        i_SetFlags;
  logic        o_Valid;
  logic        i_Ready;
  logic [31:0] o_Result;
  logic [3:0]  o_ResFlags;
  logic [3:0]  o_Flags;

  int n_total = 0;
  int n_pass  = 0;

  always #5 i_CLK = ~i_CLK;

  seq_alu #(.WIDTH(32)) dut (
    .i_CLK      (i_CLK),
    .i_RESET_N  (i_RESET_N),
    .i_Valid    (i_Valid),
    .o_Ready    (o_Ready),
    .i_A        (i_A),
    .i_B        (i_B),
    .i_Op       (i_Op),
    .i_SetFlags (i_SetFlags),
    .o_Valid    (o_Valid),
    .i_Ready    (i_Ready),
    .o_Result   (o_Result),
    .o_ResFlags (o_ResFlags),
    .o_Flags    (o_Flags)
  );

  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic req(input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic sf);
    i_Valid    = 1'b1;
    i_Op       = op;
    i_A        = a;
    i_B        = b;
    i_SetFlags = sf;
  endtask

  logic [3:0]  t_op [6];
  logic [31:0] t_a  [6];
  logic [31:0] t_b  [6];
  logic [31:0] t_r  [6];
  logic [3:0]  t_f  [6];

  initial begin
    t_op[0] = 4'd2; t_a[0] = 32'hF0F0F0F0; t_b[0] = 32'hFF00FF00;
    t_r[0]  = 32'hF000F000; t_f[0] = 4'b1000;
    t_op[1] = 4'd3; t_a[1] = 32'h0000000F; t_b[1] = 32'h000000F0;
    t_r[1]  = 32'h000000FF; t_f[1] = 4'b0000;
    t_op[2] = 4'd4; t_a[2] = 32'hAAAAAAAA; t_b[2] = 32'hAAAAAAAA;
    t_r[2]  = 32'h00000000; t_f[2] = 4'b0100;
    t_op[3] = 4'd5; t_a[3] = 32'h80000001; t_b[3] = 32'h00000001;
    t_r[3]  = 32'h00000002; t_f[3] = 4'b0010;
    t_op[4] = 4'd6; t_a[4] = 32'h00000003; t_b[4] = 32'h00000001;
    t_r[4]  = 32'h00000001; t_f[4] = 4'b0010;
    t_op[5] = 4'd9; t_a[5] = 32'h12345678; t_b[5] = 32'h9ABCDEF0;
    t_r[5]  = 32'h00000000; t_f[5] = 4'b0100;

    i_RESET_N = 1'b0; i_Valid = 1'b0; i_Ready = 1'b1;
    i_A = '0; i_B = '0; i_Op = '0; i_SetFlags = 1'b0;
    tick(); tick();
    chk("rst_ready", {31'd0, o_Ready}, 32'd0);
    chk("rst_valid", {31'd0, o_Valid}, 32'd0);
    chk("rst_result", o_Result, 32'd0);
    chk("rst_resflags", {28'd0, o_ResFlags}, 32'd0);
    chk("rst_flags", {28'd0, o_Flags}, 32'd0);
    i_RESET_N = 1'b1;
    #1;
    chk("rel_ready", {31'd0, o_Ready}, 32'd1);

    // ADD overflow, held once to see flags update only on acceptance
    i_Ready = 1'b0;
    req(4'd0, 32'h7FFFFFFF, 32'h00000001, 1'b1);
    tick();
    i_Valid = 1'b0;
    chk("add_valid", {31'd0, o_Valid}, 32'd1);
    chk("add_result", o_Result, 32'h80000000);
    chk("add_resflags", {28'd0, o_ResFlags}, 32'h9);
    chk("add_flags_pre", {28'd0, o_Flags}, 32'h0);
    i_Ready = 1'b1;
    tick();
    chk("add_flags_post", {28'd0, o_Flags}, 32'h9);
    chk("add_idle", {31'd0, o_Valid}, 32'd0);

    // SUB 5-5 then SUB 3-5 issued on the acceptance cycle
    req(4'd1, 32'd5, 32'd5, 1'b0);
    tick();
    chk("sub0_result", o_Result, 32'd0);
    chk("sub0_flags", {28'd0, o_ResFlags}, 32'h6);
    chk("sub_hold_ready", {31'd0, o_Ready}, 32'd1);
    req(4'd1, 32'd3, 32'd5, 1'b0);
    tick();
    i_Valid = 1'b0;
    chk("sub1_valid", {31'd0, o_Valid}, 32'd1);
    chk("sub1_result", o_Result, 32'hFFFFFFFE);
    chk("sub1_flags", {28'd0, o_ResFlags}, 32'h8);
    chk("sub_noset", {28'd0, o_Flags}, 32'h9);
    tick();
    chk("sub_idle", {31'd0, o_Valid}, 32'd0);

    // Back-to-back single-cycle ops, one result per cycle
    for (int i = 0; i < 6; i++) begin
      req(t_op[i], t_a[i], t_b[i], 1'b0);
      chk($sformatf("b2b%0d_ready", i), {31'd0, o_Ready}, 32'd1);
      tick();
      chk($sformatf("b2b%0d_valid", i), {31'd0, o_Valid}, 32'd1);
      chk($sformatf("b2b%0d_result", i), o_Result, t_r[i]);
      chk($sformatf("b2b%0d_flags", i), {28'd0, o_ResFlags},
          {28'd0, t_f[i]});
    end
    i_Valid = 1'b0;
    tick();
    chk("b2b_idle", {31'd0, o_Valid}, 32'd0);

    // SRA with 5 cycles of backpressure
    i_Ready = 1'b0;
    req(4'd7, 32'h80000000, 32'd4, 1'b1);
    tick();
    i_Valid = 1'b0;
    i_A = 32'h0; i_B = 32'h1F;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_result", i), o_Result, 32'hF8000000);
      chk($sformatf("bp%0d_resflags", i), {28'd0, o_ResFlags}, 32'h8);
      chk($sformatf("bp%0d_ready", i), {31'd0, o_Ready}, 32'd0);
      chk($sformatf("bp%0d_flags", i), {28'd0, o_Flags}, 32'h9);
      tick();
    end
    i_Ready = 1'b1;
    tick();
    chk("sra_flags_post", {28'd0, o_Flags}, 32'h8);

    // MUL: 32 busy cycles, operands changed after acceptance
    req(4'd8, 32'h00010001, 32'h00010001, 1'b1);
    chk("mul_ready_in", {31'd0, o_Ready}, 32'd1);
    tick();
    i_Valid = 1'b0;
    i_A = 32'hFFFFFFFF; i_B = 32'h12345678;
    for (int k = 1; k <= 32; k++) begin
      chk($sformatf("mul_busy%0d", k), {30'd0, o_Ready, o_Valid}, 32'd0);
      tick();
    end
    chk("mul_valid", {31'd0, o_Valid}, 32'd1);
    chk("mul_result", o_Result, 32'h00020001);
    chk("mul_resflags", {28'd0, o_ResFlags}, 32'h0);
    chk("mul_flags_pre", {28'd0, o_Flags}, 32'h8);
    tick();
    chk("mul_flags_post", {28'd0, o_Flags}, 32'h0);

    // Reload flags, then reset in the middle of a multiply
    req(4'd0, 32'h7FFFFFFF, 32'h00000001, 1'b1);
    tick();
    i_Valid = 1'b0;
    tick();
    chk("pre_rst_flags", {28'd0, o_Flags}, 32'h9);
    req(4'd8, 32'd3, 32'd7, 1'b1);
    tick();
    i_Valid = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    i_RESET_N = 1'b0;
    #1;
    chk("mrst_ready_low", {31'd0, o_Ready}, 32'd0);
    tick();
    chk("mrst_valid", {31'd0, o_Valid}, 32'd0);
    chk("mrst_flags", {28'd0, o_Flags}, 32'h0);
    chk("mrst_result", o_Result, 32'h0);
    i_RESET_N = 1'b1;
    #1;
    chk("mrst_idle_ready", {31'd0, o_Ready}, 32'd1);
    for (int k = 0; k < 30; k++) tick();
    chk("mrst_discard", {31'd0, o_Valid}, 32'd0);
    chk("mrst_flags_kept", {28'd0, o_Flags}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
